prach_pack: RTL

Transmit-side packer for the PRACH data path: collects time-interleaved per-antenna DSP samples (8 antennas, `NUM_STREAM` carrier streams, 16-bit I/Q) on `clk_dsp` and packs them into 256-bit Avalon-ST words, one word per stream, tagged with the stream index on the channel field. It is the inverse of the JESD-side PRACH unpacker and feeds the JESD transmit / loopback path. Frame alignment is recovered from antenna index 0 and the frame sync pulse.

---
 rtl/prach_pack.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/prach_pack.sv
// prach_pack: transmit-side PRACH packer.
//
// This block collects time-interleaved per-antenna I/Q samples (8 antennas,
// NUM_STREAM carrier streams). For each completed 8-antenna group it emits
// one 256-bit Avalon-ST word per stream. The channel field of each word
// carries the stream index.
//
// Ports
//   clk_dsp, rst_dsp_n     : clock, synchronous active-low reset
//   din_dr/din_di[s]       : 16-bit real/imag sample of stream s
//   din_dv                 : sample valid
//   din_chn                : antenna index (bits [2:0] used)
//   sync_in                : frame sync, qualified on antenna 0
//   avst_source_*          : Avalon-ST source (data/valid/channel/sop/ready)
//   stat_overflow          : sticky, a completed group was dropped
//   stat_misalign          : sticky, the antenna sequence broke
module prach_pack #(
    parameter int unsigned NUM_STREAM = 3
) (
    input  logic         clk_dsp,
    input  logic         rst_dsp_n,
    input  logic [15:0]  din_dr [NUM_STREAM],
    input  logic [15:0]  din_di [NUM_STREAM],
    input  logic         din_dv,
    input  logic [7:0]   din_chn,
    input  logic         sync_in,
    output logic [255:0] avst_source_data,
    output logic         avst_source_valid,
    output logic [7:0]   avst_source_channel,
    output logic         avst_source_sop,
    input  logic         avst_source_ready,
    output logic         stat_overflow,
    output logic         stat_misalign
);

    localparam logic [2:0] LAST_CH = 3'(NUM_STREAM - 1);

    typedef enum logic {HUNT, FILL} fill_t;
    typedef enum logic {IDLE, SEND} out_t;

    fill_t       fill, fill_n;
    out_t        ostate, ostate_n;

    logic [255:0] acc  [NUM_STREAM];
    logic [255:0] bank [NUM_STREAM];
    logic         bank_sop;
    logic [2:0]   exp, exp_n;
    logic         sync_seen, sync_n;
    logic [2:0]   ch, ch_n;

    logic         wr_en;
    logic [2:0]   wr_slot;
    logic         group_done;
    logic         misalign_set;
    logic         last_leave;
    logic         load;

    logic [2:0]   chn;
    logic         is_ant0;
    logic         chn_unused;

    assign chn        = din_chn[2:0];
    assign chn_unused = ^din_chn[7:3];
    assign is_ant0    = (chn == 3'd0);

    // ------------------------------------------------------------------
    // Accumulator FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_dsp) begin
        if (!rst_dsp_n) begin
            fill      <= HUNT;
            exp       <= '0;
            sync_seen <= 1'b0;
        end else begin
            fill      <= fill_n;
            exp       <= exp_n;
            sync_seen <= sync_n;
        end
    end

    // Accumulator FSM: next state and slot-write decode
    always_comb begin
        fill_n       = fill;
        exp_n        = exp;
        sync_n       = sync_seen;
        wr_en        = 1'b0;
        wr_slot      = '0;
        group_done   = 1'b0;
        misalign_set = 1'b0;
        case (fill)
            HUNT: begin
                if (din_dv && is_ant0) begin
                    wr_en   = 1'b1;
                    exp_n   = 3'd1;
                    sync_n  = sync_in;
                    fill_n  = FILL;
                end
            end
            FILL: begin
                if (din_dv) begin
                    if (chn == exp) begin
                        wr_en   = 1'b1;
                        wr_slot = exp;
                        exp_n   = exp + 3'd1;
                        if (exp == 3'd7) begin
                            group_done = 1'b1;
                            fill_n     = HUNT;
                        end
                    end else begin
                        misalign_set = 1'b1;
                        if (is_ant0) begin
                            // Restart on this antenna 0 instead of losing it.
                            wr_en  = 1'b1;
                            exp_n  = 3'd1;
                            sync_n = sync_in;
                        end else begin
                            fill_n = HUNT;
                        end
                    end
                end
            end
            default: fill_n = HUNT;
        endcase
    end

    // Accumulator slot storage
    always_ff @(posedge clk_dsp) begin
        if (!rst_dsp_n) begin
            for (int unsigned s = 0; s < NUM_STREAM; s++)
                acc[s] <= '0;
        end else if (wr_en) begin
            for (int unsigned s = 0; s < NUM_STREAM; s++)
                for (int unsigned k = 0; k < 8; k++)
                    if (wr_slot == 3'(k))
                        acc[s][255-32*k -: 32] <= {din_di[s], din_dr[s]};
        end
    end

    // ------------------------------------------------------------------
    // Hold bank: a bank that is still draining is never overwritten. The
    // completed group takes slots 0..6 from acc and slot 7 from the inputs.
    // ------------------------------------------------------------------
    assign last_leave = (ostate == SEND) && avst_source_ready && (ch == LAST_CH);
    assign load       = group_done && ((ostate == IDLE) || last_leave);

    always_ff @(posedge clk_dsp) begin
        if (!rst_dsp_n) begin
            for (int unsigned s = 0; s < NUM_STREAM; s++)
                bank[s] <= '0;
            bank_sop      <= 1'b0;
            stat_overflow <= 1'b0;
            stat_misalign <= 1'b0;
        end else begin
            if (load) begin
                for (int unsigned s = 0; s < NUM_STREAM; s++)
                    bank[s] <= {acc[s][255:32], din_di[s], din_dr[s]};
                bank_sop <= sync_seen;
            end
            if (group_done && !load)
                stat_overflow <= 1'b1;
            if (misalign_set)
                stat_misalign <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_dsp) begin
        if (!rst_dsp_n) begin
            ostate <= IDLE;
            ch     <= '0;
        end else begin
            ostate <= ostate_n;
            ch     <= ch_n;
        end
    end

    // Output FSM: next state
    always_comb begin
        ostate_n = ostate;
        ch_n     = ch;
        case (ostate)
            IDLE: begin
                if (load) begin
                    ostate_n = SEND;
                    ch_n     = '0;
                end
            end
            SEND: begin
                if (avst_source_ready) begin
                    if (ch == LAST_CH) begin
                        ch_n     = '0;
                        ostate_n = load ? SEND : IDLE;
                    end else begin
                        ch_n = ch + 3'd1;
                    end
                end
            end
            default: begin
                ostate_n = IDLE;
                ch_n     = '0;
            end
        endcase
    end

    // Output FSM: outputs
    always_comb begin
        avst_source_valid   = 1'b0;
        avst_source_channel = '0;
        avst_source_sop     = 1'b0;
        avst_source_data    = '0;
        if (ostate == SEND) begin
            avst_source_valid   = 1'b1;
            avst_source_channel = {5'b0, ch};
            avst_source_sop     = bank_sop && (ch == 3'd0);
            for (int unsigned s = 0; s < NUM_STREAM; s++)
                if (ch == 3'(s))
                    avst_source_data = bank[s];
        end
    end

endmodule
